rom_arbiter: RTL and testbench

Round-robin arbiter that shares the single 8-entry one-hot-addressed lookup ROM among `NUM_REQ` requesters. Each requester issues a 3-bit entry index with a valid/ready handshake. The arbiter converts the index to the ROM's one-hot address, sequences the ROM's one-cycle registered read, and returns the data to the granted requester with a one-cycle response strobe. It sits between the requester blocks and the ROM, and is the ROM's only driver.

---
 rtl/rom_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rom_arbiter.sv | 111 +++++++++++
 tb/tb_rom_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and helpers for the lookup-ROM arbiter.
// Holds the ROM geometry, the arbiter FSM states and the index-to-one-hot decode.
package rom_pkg;

    localparam int ROM_IDX_W  = 3;
    localparam int ROM_DEPTH  = 8;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        RESP
    } rom_arb_state_e;

    function automatic logic [ROM_DEPTH-1:0] rom_onehot(
        input logic [ROM_IDX_W-1:0] idx
    );
        return ROM_DEPTH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts just above the last winner.
// Outputs a one-hot grant and the binary index of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);

    logic w_found;

    // Pass one covers requesters above last, pass two wraps to 0..last.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_en && !w_found && i_req[i] && (IW'(i) > i_last)) begin
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_en && !w_found && i_req[i]) begin
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-read lookup ROM among NUM_REQ requesters.
// Accept, read, capture, respond: one transaction in flight at a time.
module rom_arbiter
    import rom_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ROM_IDX_W-1:0]  req_idx,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [ROM_DATA_W-1:0]         rsp_data,
    output logic                          rom_en,
    output logic [ROM_DEPTH-1:0]          rom_addr,
    input  logic [ROM_DATA_W-1:0]         rom_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rom_arb_state_e       r_state;
    rom_arb_state_e       w_next;
    logic [IW-1:0]        r_last;
    logic [IW-1:0]        r_win;
    logic [ROM_IDX_W-1:0] r_idx;
    logic [ROM_DATA_W-1:0] r_rsp_data;

    logic                 w_arb_en;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IW-1:0]        w_win;
    logic [ROM_IDX_W-1:0] w_sel_idx;

    // Arbitration is live in IDLE and RESP; reset suppresses any accept.
    assign w_arb_en = !rst && ((r_state == IDLE) || (r_state == RESP));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .i_en   (w_arb_en),
        .o_gnt  (w_gnt),
        .o_idx  (w_win)
    );

    assign req_ready = w_gnt;
    assign rsp_data  = r_rsp_data;

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_idx = req_idx[i*ROM_IDX_W +: ROM_IDX_W];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        rom_en   = 1'b0;
        rom_addr = '0;
        unique case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_next = READ;
                end
            end
            READ: begin
                rom_en   = 1'b1;
                rom_addr = rom_onehot(r_idx);
                w_next   = WAIT;
            end
            WAIT: begin
                w_next = RESP;
            end
            RESP: begin
                w_next = (|w_gnt) ? READ : IDLE;
            end
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_state == RESP) && (r_win == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= IW'(NUM_REQ - 1);
            r_win      <= '0;
            r_idx      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_next;
            if (|w_gnt) begin
                r_idx  <= w_sel_idx;
                r_win  <= w_win;
                r_last <= w_win;
            end
            if (r_state == WAIT) begin
                r_rsp_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural ROM and a response scoreboard.
// Expected responses are queued at each accept and matched when rsp_valid fires.
module tb_rom_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [3*N-1:0] req_idx = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rom_en;
    logic [7:0]     rom_addr;
    logic [7:0]     rom_data = '0;

    typedef struct packed {
        int         req;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    rom_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    function automatic logic [7:0] rom_model(input logic en,
                                             input logic [7:0] a);
        logic [7:0] d;
        d = 8'h00;
        if (en && $onehot(a)) begin
            for (int i = 0; i < 8; i++) begin
                if (a[i]) d = exp_data(i);
            end
        end
        return d;
    endfunction

    always @(posedge clk) rom_data <= rom_model(rom_en, rom_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (|rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                m_e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << m_e.req));
                chk("rsp_data", 32'(rsp_data), 32'(m_e.data));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_idx(input int r, input int v);
        req_idx[3*r +: 3] = 3'(v);
    endtask

    task automatic grant(input int r, input int idx);
        exp_t e;
        chk("req_ready", 32'(req_ready), 32'(1 << r));
        e.req  = r;
        e.data = exp_data(idx);
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({p, "_rsp_data"}, 32'(rsp_data), 32'h0);
        chk({p, "_rom_en"}, 32'(rom_en), 32'h0);
        chk({p, "_rom_addr"}, 32'(rom_addr), 32'h0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        nxt();
        nxt();
        smp();
        chk_zero("rst");
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Single request: requester 2, idx 5
        reset_dut();
        req_valid = 4'b0100;
        set_idx(2, 5);
        smp();
        grant(2, 5);
        nxt();
        req_valid = '0;
        smp();
        chk("t1_rom_en", 32'(rom_en), 32'h1);
        chk("t1_rom_addr", 32'(rom_addr), 32'h20);
        chk("t1_req_ready", 32'(req_ready), 32'h0);
        nxt();
        smp();
        chk("t2_rom_en", 32'(rom_en), 32'h0);
        chk("t2_rom_addr", 32'(rom_addr), 32'h0);
        nxt();
        smp();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t3_rsp_data", 32'(rsp_data), 32'h66);
        nxt();

        // All requesters valid continuously: rotate 0,1,2,3,0
        reset_dut();
        req_valid = 4'hF;
        for (int r = 0; r < N; r++) set_idx(r, r);
        for (int g = 0; g < 5; g++) begin
            smp();
            grant(g % N, g % N);
            if (g < 4) begin
                nxt();
                smp();
                chk("rr_gap1", 32'(req_ready), 32'h0);
                nxt();
                smp();
                chk("rr_gap2", 32'(req_ready), 32'h0);
                nxt();
            end
        end
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        smp();
        nxt();

        // Index sweep on requester 0, re-requesting in each RESP cycle
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b0001;
            set_idx(0, i);
            smp();
            grant(0, i);
            nxt();
            req_valid = '0;
            smp();
            chk("sweep_rom_addr", 32'(rom_addr), 32'(1 << i));
            nxt();
            nxt();
        end
        smp();
        nxt();

        // Fairness after reset: 1 before 3, then 1 again at 3's RESP
        reset_dut();
        req_valid = 4'b1010;
        set_idx(1, 1);
        set_idx(3, 3);
        smp();
        grant(1, 1);
        nxt();
        req_valid = 4'b1000;
        nxt();
        nxt();
        smp();
        grant(3, 3);
        nxt();
        req_valid = 4'b0010;
        nxt();
        nxt();
        smp();
        grant(1, 1);
        chk("fair_resp3", 32'(rsp_valid), 32'h8);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        smp();
        nxt();

        // Reset during READ
        reset_dut();
        req_valid = 4'b0100;
        set_idx(2, 4);
        smp();
        grant(2, 4);
        nxt();
        req_valid = '0;
        rst = 1'b1;
        smp();
        chk("abort_read_rom_en", 32'(rom_en), 32'h1);
        void'(sb.pop_back());
        nxt();
        rst = 1'b0;
        smp();
        chk_zero("abort_read");
        nxt();
        req_valid = 4'b0101;
        set_idx(0, 6);
        set_idx(2, 4);
        smp();
        grant(0, 6);
        nxt();
        req_valid = 4'b0100;
        nxt();
        nxt();
        smp();
        grant(2, 4);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        smp();
        nxt();

        // Reset during WAIT
        req_valid = 4'b0010;
        set_idx(1, 6);
        smp();
        grant(1, 6);
        nxt();
        req_valid = '0;
        nxt();
        rst = 1'b1;
        smp();
        chk("abort_wait_hold", 32'(rsp_data), 32'h55);
        void'(sb.pop_back());
        nxt();
        rst = 1'b0;
        smp();
        chk_zero("abort_wait");
        nxt();
        req_valid = 4'b1001;
        set_idx(0, 2);
        set_idx(3, 7);
        smp();
        grant(0, 2);
        nxt();
        req_valid = 4'b1000;
        nxt();
        nxt();
        smp();
        grant(3, 7);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        smp();
        nxt();

        // Idle hygiene: nothing moves, rsp_data holds
        for (int c = 0; c < 20; c++) begin
            smp();
            chk("idle_rom_en", 32'(rom_en), 32'h0);
            chk("idle_rom_addr", 32'(rom_addr), 32'h0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("idle_rsp_data", 32'(rsp_data), 32'h88);
            nxt();
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
